// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the fetch-stage PC generator
package pc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    localparam int INST_BYTES = 4;

    // Two-bit saturating direction counter: taken moves toward ST, not-taken toward SNT.
    function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
        ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != ST) begin
                result = ctr_t'(ctr + 2'd1);
            end
        end else if (ctr != SNT) begin
            result = ctr_t'(ctr - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped branch target buffer with combinational lookup
// and a synchronous training port; a same-cycle lookup sees pre-update contents.
module btb_table
    import pc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - IW - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TW-1:0]          tag_q    [BTB_ENTRIES];
    logic [XLEN-3:0]        target_q [BTB_ENTRIES];
    ctr_t                   ctr_q    [BTB_ENTRIES];

    logic [IW-1:0] lk_idx;
    logic [IW-1:0] up_idx;
    logic [TW-1:0] lk_tag;
    logic [TW-1:0] up_tag;
    logic          lk_hit;
    logic          up_hit;

    assign lk_idx = lookup_pc[IW+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IW+2];
    assign up_idx = update_pc[IW+1:2];
    assign up_tag = update_pc[XLEN-1:IW+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        lookup_taken  = lk_hit && (ctr_q[lk_idx] inside {WT, ST});
        lookup_target = '0;
        if (lookup_taken) begin
            lookup_target = {target_q[lk_idx], 2'b00};
        end
    end

    // Only valid bits are reset; tag/target/counter contents are gated by valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_update(ctr_q[up_idx], update_taken);
                if (update_taken) begin
                    target_q[up_idx] <= update_target[XLEN-1:2];
                end
            end else if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target[XLEN-1:2];
                ctr_q[up_idx]    <= WT;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], update_pc[1:0], update_target[1:0]};

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with priority next-PC selection
// (reset, trap, redirect, stall, BTB prediction, sequential).
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    logic [XLEN-1:0] next_pc;

    btb_table #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clock         (clock),
        .reset         (reset),
        .lookup_pc     (pc),
        .lookup_taken  (pred_taken),
        .lookup_target (pred_target),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken)
    );

    always_comb begin
        next_pc = pc + XLEN'(INST_BYTES);
        if (trap_valid) begin
            next_pc = {trap_vector[XLEN-1:2], 2'b00};
        end else if (redirect_valid) begin
            next_pc = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (stall) begin
            next_pc = pc;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= next_pc;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{trap_vector[1:0], redirect_pc[1:0]};

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen against an arithmetic reference model
module tb_pc_gen;

    localparam int          N  = 16;
    localparam logic [31:0] RV = 32'h100;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .BTB_ENTRIES  (N)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_taken   (update_taken),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        int          phase;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   phase    = 0;

    // Reference BTB: one record per slot, indexed by word address modulo N.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_pc;

    function automatic int slot_of(input logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (4 * N);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot_of(a)] && (m_tag[slot_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] m_pred(input logic [31:0] a, output logic pt);
        pt = m_hit(a) && (m_ctr[slot_of(a)] >= 2);
        return pt ? m_tgt[slot_of(a)] : 32'h0;
    endfunction

    task automatic model_step();
        logic        pt;
        logic [31:0] tgt;
        logic [31:0] npc;
        int          s;
        tgt = m_pred(m_pc, pt);
        if (reset)               npc = RV;
        else if (trap_valid)     npc = trap_vector & ~32'h3;
        else if (redirect_valid) npc = redirect_pc & ~32'h3;
        else if (stall)          npc = m_pc;
        else if (pt)             npc = tgt;
        else                     npc = m_pc + 32'd4;
        s = slot_of(update_pc);
        if (reset) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        end else if (update_valid) begin
            if (m_hit(update_pc)) begin
                if (update_taken) begin
                    m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = update_target & ~32'h3;
                end else begin
                    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (update_taken) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = tag_of(update_pc);
                m_tgt[s]   = update_target & ~32'h3;
                m_ctr[s]   = 2;
            end
        end
        m_pc = npc;
        tgt = m_pred(m_pc, pt);
        exp_q.push_back('{pc: m_pc, pt: pt, tgt: tgt, phase: phase});
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        model_step();
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 0; stall = 0; redirect_valid = 0; trap_valid = 0;
        update_valid = 0; update_taken = 0;
        redirect_pc = 0; trap_vector = 0; update_pc = 0; update_target = 0;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1; redirect_pc = a;
        tick();
        redirect_valid = 0;
    endtask

    task automatic train(input logic [31:0] a, input logic [31:0] t, input logic tk);
        update_valid = 1; update_pc = a; update_target = t; update_taken = tk;
        tick();
        update_valid = 0; update_taken = 0;
    endtask

    task automatic check_now(input string name, input logic [31:0] epc,
                             input logic ept, input logic [31:0] etgt);
        checks++;
        if (pc !== epc || pred_taken !== ept || pred_target !== etgt) begin
            failures++;
            $display("FAIL %s: pc=%h pred_taken=%b pred_target=%h, required pc=%h pred_taken=%b pred_target=%h",
                     name, pc, pred_taken, pred_target, epc, ept, etgt);
        end
    endtask

    always @(posedge clock) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || pred_taken !== e.pt || pred_target !== e.tgt) begin
                failures++;
                $display("FAIL scoreboard phase=%0d: pc=%h pred_taken=%b pred_target=%h, required pc=%h pred_taken=%b pred_target=%h",
                         e.phase, pc, pred_taken, pred_target, e.pc, e.pt, e.tgt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        m_pc = 32'h0;
        @(negedge clock);

        phase = 1;
        reset = 1;
        tick(); tick();
        reset = 0;
        check_now("reset_state", 32'h100, 1'b0, 32'h0);
        tick(); check_now("seq_104", 32'h104, 1'b0, 32'h0);
        tick(); check_now("seq_108", 32'h108, 1'b0, 32'h0);

        phase = 2;
        stall = 1;
        tick(); tick(); tick();
        check_now("stall_hold", 32'h108, 1'b0, 32'h0);
        redirect_valid = 1; redirect_pc = 32'h203;
        tick();
        idle();
        check_now("redirect_over_stall", 32'h200, 1'b0, 32'h0);
        trap_valid = 1; trap_vector = 32'h80; redirect_valid = 1; redirect_pc = 32'h300;
        tick();
        idle();
        check_now("trap_over_redirect", 32'h80, 1'b0, 32'h0);

        phase = 3;
        train(32'h10, 32'h40, 1);
        redirect_to(32'h8);
        tick();
        tick();
        check_now("btb_hit_predict", 32'h10, 1'b1, 32'h40);
        tick();
        check_now("btb_follow_target", 32'h40, 1'b0, 32'h0);
        train(32'h10, 32'h0, 0);
        train(32'h10, 32'h0, 0);
        redirect_to(32'h10);
        check_now("btb_trained_not_taken", 32'h10, 1'b0, 32'h0);
        tick();
        check_now("btb_fall_through", 32'h14, 1'b0, 32'h0);

        phase = 4;
        repeat (4) train(32'h10, 32'h40, 1);
        train(32'h10, 32'h0, 0);
        redirect_to(32'h10);
        check_now("ctr_saturated", 32'h10, 1'b1, 32'h40);
        train(32'h10 + 4 * N, 32'h300, 1);
        redirect_to(32'h10);
        check_now("alias_replaced", 32'h10, 1'b0, 32'h0);
        train(32'h24, 32'h99, 0);
        redirect_to(32'h24);
        check_now("miss_not_taken_no_alloc", 32'h24, 1'b0, 32'h0);

        phase = 5;
        redirect_to(32'hFFFF_FFFC);
        check_now("top_of_space", 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        check_now("pc_wrap", 32'h0, 1'b0, 32'h0);
        redirect_to(32'h10);
        update_valid = 1; update_pc = 32'h10; update_target = 32'h500; update_taken = 1;
        check_now("same_cycle_old_entry", 32'h10, 1'b0, 32'h0);
        tick();
        idle();
        check_now("same_cycle_no_jump", 32'h14, 1'b0, 32'h0);
        redirect_to(32'h10);
        check_now("same_cycle_new_entry", 32'h10, 1'b1, 32'h500);

        phase = 6;
        reset = 1; update_valid = 1; update_pc = 32'h10; update_target = 32'h500; update_taken = 1;
        tick();
        idle();
        check_now("mid_reset", 32'h100, 1'b0, 32'h0);
        redirect_to(32'h10);
        check_now("mid_reset_cleared", 32'h10, 1'b0, 32'h0);

        phase = 7;
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom % 100) == 0;
            trap_valid     = ($urandom % 20) == 0;
            redirect_valid = ($urandom % 8) == 0;
            stall          = ($urandom % 6) == 0;
            update_valid   = ($urandom % 2) == 0;
            update_taken   = ($urandom % 3) != 0;
            redirect_pc    = $urandom_range(0, 511);
            trap_vector    = $urandom_range(0, 511);
            update_pc      = 32'($urandom_range(0, 127)) << 2;
            update_target  = $urandom_range(0, 511);
            tick();
        end
        idle();

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it selects the next PC from the following sources, in priority order: reset, trap, redirect, stall hold, BTB prediction, sequential increment. It sits at the head of the IF stage, drives the instruction-memory address, and receives stall from ID, redirects from EX, and traps from the exception unit.

## Interface
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 0, PC value after reset; must be 4-byte aligned.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  ID hazard stall; hold PC.
- redirect_valid  in  1  EX branch/jump resolved against the prediction; load redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored.
- trap_valid  in  1  exception/interrupt; load trap_vector.
- trap_vector  in  XLEN  trap handler address; bits [1:0] ignored.
- update_valid  in  1  resolved control-flow instruction; train the BTB.
- update_pc  in  XLEN  address of the resolved branch.
- update_target  in  XLEN  resolved taken target.
- update_taken  in  1  resolved direction.
- pc  out  XLEN  current fetch address, registered.
- pred_taken  out  1  BTB predicts taken for pc; combinational from pc and BTB state.
- pred_target  out  XLEN  predicted target for pc; valid only when pred_taken=1, otherwise 0.

## Operation
- Index: IW = log2(BTB_ENTRIES). idx = pc[IW+1:2]. tag = pc[XLEN-1:IW+2].
- Entry contents: valid, tag, target[XLEN-1:2], ctr[1:0].
- Hit: the entry at idx has valid set and its tag matches.
- pred_taken = hit & ctr[1]. When pred_taken=1, pred_target = {target, 2'b00}.
- Next PC, highest priority first:
  - reset → RESET_VECTOR
  - trap_valid → {trap_vector[XLEN-1:2], 2'b00}
  - redirect_valid → {redirect_pc[XLEN-1:2], 2'b00}
  - stall → pc (hold)
  - pred_taken → pred_target
  - otherwise → pc + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
- BTB update, when update_valid is asserted and reset is not:
  - Hit on update_pc:
    - ctr increments if update_taken, otherwise decrements; saturates at 0 and 3.
    - If update_taken, target is rewritten with update_target.
  - Miss and update_taken: allocate the entry (overwriting any existing one) with valid=1, tag, target, ctr=2 (weakly taken).
  - Miss and not taken: no change.
- BTB update proceeds regardless of stall, redirect or trap.
- reset clears every valid bit in one cycle. Targets, tags and counters are don't-care after reset.

## Timing
- Reset values: pc=RESET_VECTOR, pred_taken=0, pred_target=0 (all BTB entries invalid).
- The next PC is registered. A redirect or trap asserted in cycle N appears on pc in cycle N+1.
- BTB lookup is zero-cycle: pred_* reflect the pc of the same cycle.
- BTB update latency is one cycle:
  - An update at edge N is visible to lookups from cycle N+1 onward.
  - A same-cycle lookup at the same index sees the pre-update contents.
- stall and a BTB write in the same cycle: pc holds and the write still lands.
- reset while update_valid is asserted: reset wins and the entry ends invalid.
- No handshakes. All inputs are sampled only at the rising edge of clock.

## Structure
- Package pc_pkg holds:
  - counter encodings SNT=2'd0, WNT=2'd1, WT=2'd2, ST=2'd3
  - constant INST_BYTES=4
  - function for the saturating counter update
- Sub-module btb_table, parametrised by XLEN and BTB_ENTRIES:
  - owns the storage, the combinational lookup port and the synchronous update port.
- pc_gen keeps the PC register and the next-PC priority mux.

## Test plan
- Reset and sequential fetch: assert reset 2 cycles with RESET_VECTOR=0x100 → pc=0x100, pred_taken=0. Release reset → pc=0x104, then 0x108.
- Stall vs redirect: stall=1 for 3 cycles → pc holds. stall=1 with redirect_valid=1, redirect_pc=0x203 → next pc=0x200. trap_valid=1 (vector 0x80) together with redirect_valid=1 → next pc=0x80.
- BTB training:
  - Step 1: update_valid, update_pc=0x10, update_target=0x40, taken=1.
  - Step 2: fetch reaches 0x10 → pred_taken=1, pred_target=0x40, next pc=0x40.
  - Step 3: two not-taken updates at 0x10 (ctr 2→1→0) → fetch at 0x10 falls through to 0x14.
- Counter saturation and aliasing:
  - Four taken updates at 0x10 leave ctr=3; one not-taken update keeps pred_taken=1.
  - A taken update at 0x10+4*BTB_ENTRIES replaces the entry → fetch at 0x10 misses.
  - A not-taken update on a miss allocates nothing.
- Boundaries:
  - pc=0xFFFFFFFC with no BTB hit → next pc=0.
  - Update and lookup at the same index in the same cycle → lookup reflects the old entry; the next visit reflects the new entry.
  - Reset mid-run after training → all predictions cleared, pred_taken=0.
